alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Sequencer in front of the 16-bit combinational ALU. Accepts one operation per request (valid/ready),
//  drives the ALU operand/opcode lines for single-cycle ops, and runs MUL itself as an iterative
//  shift-add over DATA_W cycles. Owns the architectural HI/LO product registers and returns results
//  through a valid/ready response port to the core pipeline.
// PARAMETERS
//  DATA_W  16  operand/result width; HI/LO are DATA_W each, product is 2*DATA_W
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  rst          in   1       asynchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       controller can accept (high only in IDLE)
//  req_op       in   4       opcode, alu_pkg encodings
//  req_a        in   DATA_W  left operand
//  req_b        in   DATA_W  right operand / immediate
//  alu_op       out  4       opcode to ALU
//  alu_lvalue   out  DATA_W  left operand to ALU
//  alu_rvalue   out  DATA_W  right operand to ALU
//  alu_result   in   DATA_W  ALU combinational result
//  rsp_valid    out  1       response held until accepted
//  rsp_ready    in   1       consumer accepts response
//  rsp_result   out  DATA_W  result (MUL: low product half)
//  rsp_err      out  1       opcode not in {ADD,SUB,PASS,MUL,AND,SLL,CMP}
//  hi           out  DATA_W  product[2*DATA_W-1:DATA_W]
//  lo           out  DATA_W  product[DATA_W-1:0]
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 after reset (IDLE); rsp_valid, rsp_err, rsp_result, hi, lo, alu_* = 0.
//  Reset mid-operation discards the in-flight op; hi/lo cleared, no response produced.
//  FSM IDLE -> EXEC | MUL | RESP; EXEC -> RESP; MUL -> RESP; RESP -> IDLE.
//  IDLE: on req_valid&&req_ready latch op/a/b. MUL -> MUL; illegal op -> RESP with rsp_err=1,
//   rsp_result=0; else -> EXEC.
//  EXEC (1 cycle): alu_op/alu_lvalue/alu_rvalue driven from latched values; alu_result captured
//   into rsp_result at end of cycle. Outside EXEC, alu_* driven to 0 (no X into the ALU).
//  MUL: unsigned shift-add, DATA_W cycles, counter 0..DATA_W-1. Per cycle: if mplier[0],
//   {c,acc_hi} = acc_hi + mcand (DATA_W+1 bits); then {c,acc_hi,acc_lo} >>= 1 with mplier in acc_lo.
//   On the last cycle hi<=acc_hi, lo<=acc_lo, rsp_result<=acc_lo, in the same edge RESP is entered.
//  hi/lo change only on MUL completion; other ops and illegal ops leave them untouched.
//  Latency, accept edge N: single-cycle op rsp_valid high after edge N+2; MUL after edge N+1+DATA_W;
//   illegal op after edge N+1.
//  RESP: rsp_valid=1, rsp_result/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE.
//   req_ready is not asserted in the handshake cycle (one-cycle bubble between ops).
//  req_valid while busy is ignored (no latch); requester must hold until req_ready.
//  Operand edges: MUL 0xFFFF*0xFFFF must not lose the carry (17-bit add); a*0 and 0*b still take
//   full DATA_W cycles (no early exit); SLL with amount >= DATA_W yields whatever ALU returns.
// STRUCTURE
//  alu_pkg: ALU_OP_ADD=4'b0000, SUB=4'b0010, PASS=4'b0011, MUL=4'b0100, AND=4'b0101,
//   SLL=4'b0110, CMP=4'b1101; FSM state encodings; DATA_W default.
//  Sub-module alu_mul_iter: start/done shift-add multiplier with counter and acc; controller
//   owns FSM, handshakes, ALU drive and hi/lo.
// TESTING
//  1 Reset: assert rst mid-MUL (cycle 5) -> rsp_valid never rises, hi=lo=0, req_ready=1 after release.
//  2 ADD a=0x1234 b=0x0FFF, rsp_ready=1 -> alu_op=0000 in EXEC, rsp_result=0x2233 two edges after accept.
//  3 MUL a=0xFFFF b=0xFFFF -> after 17 edges hi=0xFFFE, lo=0x0001, rsp_result=0x0001; MUL 3*5 -> hi=0,lo=15.
//  4 Backpressure: SUB 5-7, rsp_ready=0 for 4 cycles -> rsp_valid/rsp_result=0xFFFE held, req_ready=0.
//  5 Back-to-back: PASS b=0x00AB then AND 0xF0F0&0x0FF0 with req_valid always high -> 0x00AB, 0x00F0,
//    one bubble between; hi/lo unchanged from previous MUL.
//  6 Illegal op 4'b1111 -> rsp_err=1, rsp_result=0 after one edge; ALU inputs stay 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and width default for the ALU sequencer.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OP_PASS = 4'b0011;
    localparam logic [3:0] ALU_OP_MUL  = 4'b0100;
    localparam logic [3:0] ALU_OP_AND  = 4'b0101;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0110;
    localparam logic [3:0] ALU_OP_CMP  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_PASS, ALU_OP_MUL,
            ALU_OP_AND, ALU_OP_SLL, ALU_OP_CMP: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: loads on start, then runs exactly W steps.
// product is the value the accumulator takes at the end of the current step.
module alu_mul_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          running;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  mcand_r;
    logic [W:0]    sum;
    logic [2*W:0]  shifted;

    // Adder is W+1 bits so the carry of e.g. FFFF+FFFF shifts back into acc_hi.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
        shifted = {sum, acc_lo};
        product = shifted[2*W:1];
    end

    assign done = running && (cnt == CW'(W-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand_r <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= mplier;
            mcand_r <= mcand;
        end else if (running) begin
            acc_hi <= product[2*W-1:W];
            acc_lo <= product[W-1:0];
            if (done) running <= 1'b0;
            else      cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer in front of the combinational ALU; runs MUL
// itself and owns the HI/LO product registers.
//   state   | meaning
//   IDLE    | waiting for a request, req_ready high
//   EXEC    | single-cycle op driven onto the ALU, result captured at edge
//   MUL     | iterative multiply in progress
//   RESP    | response presented until rsp_ready
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_lvalue,
    output logic [DATA_W-1:0] alu_rvalue,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);
    state_t              state, state_nx;
    logic [3:0]          op_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    // Operands go straight from the request port so the first step runs the cycle after accept.
    assign mul_start = accept && (req_op == ALU_OP_MUL);

    alu_mul_iter #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (req_a),
        .mplier  (req_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_nx   = state;
        alu_op     = 4'b0000;
        alu_lvalue = '0;
        alu_rvalue = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == ALU_OP_MUL)   state_nx = ST_MUL;
                    else if (!op_legal(req_op)) state_nx = ST_RESP;
                    else                        state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op     = op_r;
                alu_lvalue = a_r;
                alu_rvalue = b_r;
                state_nx   = ST_RESP;
            end
            ST_MUL:  if (mul_done)  state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_r    <= req_op;
                a_r     <= req_a;
                b_r     <= req_b;
                rsp_err <= !op_legal(req_op);
                if (!op_legal(req_op)) rsp_result <= '0;
            end
            if (state == ST_EXEC) rsp_result <= alu_result;
            if (state == ST_MUL && mul_done) begin
                hi         <= mul_product[2*DATA_W-1:DATA_W];
                lo         <= mul_product[DATA_W-1:0];
                rsp_result <= mul_product[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, hand-written
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_lvalue, alu_rvalue, alu_result;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] rsp_result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_hi, m_lo;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_lvalue(alu_lvalue), .alu_rvalue(alu_rvalue),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .hi(hi), .lo(lo), .busy(busy)
    );

    // Behavioural stand-in for the external combinational ALU.
    function automatic logic [15:0] bench_alu(input logic [3:0] op, input logic [15:0] l, input logic [15:0] r);
        case (op)
            4'b0000: return l + r;
            4'b0010: return l - r;
            4'b0011: return r;
            4'b0101: return l & r;
            4'b0110: return (r >= 16) ? 16'h0000 : (l << r[3:0]);
            4'b1101: return (l < r) ? 16'h0001 : 16'h0000;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_result = bench_alu(alu_op, alu_lvalue, alu_rvalue);

    function automatic bit is_legal(input logic [3:0] op);
        return op == 4'b0000 || op == 4'b0010 || op == 4'b0011 || op == 4'b0100 ||
               op == 4'b0101 || op == 4'b0110 || op == 4'b1101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one op; lat counts rising edges from the accept edge (inclusive)
    // until rsp_valid is seen, or -1 on timeout.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, output logic [15:0] res, output logic err,
                         output int lat, output bit alu_ok, output bit hold_ok, output bit post_ok);
        bit done;
        bit single;
        int g;
        single  = (op != 4'b0100) && is_legal(op);
        alu_ok  = 1'b1;
        hold_ok = 1'b1;
        post_ok = 1'b1;
        done    = 1'b0;
        lat     = 0;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            lat++;
            #1 req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid) done = 1'b1;
            else if (single && lat == 1) begin
                if (alu_op !== op || alu_lvalue !== a || alu_rvalue !== b) alu_ok = 1'b0;
            end else if (alu_op !== 4'b0 || alu_lvalue !== 16'h0 || alu_rvalue !== 16'h0 || !busy)
                alu_ok = 1'b0;
        end
        if (!done) lat = -1;
        res = rsp_result;
        err = rsp_err;
        if (alu_op !== 4'b0 || alu_lvalue !== 16'h0 || alu_rvalue !== 16'h0) alu_ok = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            if (!rsp_valid || rsp_result !== res || rsp_err !== err || req_ready) hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        if (rsp_valid || !req_ready || busy) post_ok = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        int          hold;
        logic [15:0] res;
        logic        err;
        int          lat;
        logic [15:0] ehi, elo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [15:0] res;
        logic        err;
        int          lat;
        bit          aok, hok, pok;
        bit          seen;
        logic [3:0]  legal_ops[7];
        logic [3:0]  bad_ops[9];

        vecs[0]  = '{4'b0000, 16'h1234, 16'h0FFF, 0, 16'h2233, 1'b0, 2,  16'h0000, 16'h0000};
        vecs[1]  = '{4'b0100, 16'hFFFF, 16'hFFFF, 1, 16'h0001, 1'b0, 17, 16'hFFFE, 16'h0001};
        vecs[2]  = '{4'b0100, 16'h0003, 16'h0005, 0, 16'h000F, 1'b0, 17, 16'h0000, 16'h000F};
        vecs[3]  = '{4'b0010, 16'h0005, 16'h0007, 4, 16'hFFFE, 1'b0, 2,  16'h0000, 16'h000F};
        vecs[4]  = '{4'b1111, 16'h1234, 16'h5678, 2, 16'h0000, 1'b1, 1,  16'h0000, 16'h000F};
        vecs[5]  = '{4'b0110, 16'h0001, 16'h0004, 0, 16'h0010, 1'b0, 2,  16'h0000, 16'h000F};
        vecs[6]  = '{4'b0110, 16'h00FF, 16'h0014, 0, 16'h0000, 1'b0, 2,  16'h0000, 16'h000F};
        vecs[7]  = '{4'b1101, 16'h0003, 16'h0009, 0, 16'h0001, 1'b0, 2,  16'h0000, 16'h000F};
        vecs[8]  = '{4'b0100, 16'h0000, 16'hBEEF, 0, 16'h0000, 1'b0, 17, 16'h0000, 16'h0000};
        vecs[9]  = '{4'b0100, 16'h1234, 16'h0000, 0, 16'h0000, 1'b0, 17, 16'h0000, 16'h0000};
        vecs[10] = '{4'b0100, 16'h8000, 16'h0002, 0, 16'h0000, 1'b0, 17, 16'h0001, 16'h0000};
        vecs[11] = '{4'b0011, 16'hFFFF, 16'h00AB, 1, 16'h00AB, 1'b0, 2,  16'h0001, 16'h0000};
        vecs[12] = '{4'b0001, 16'hAAAA, 16'h5555, 0, 16'h0000, 1'b1, 1,  16'h0001, 16'h0000};

        legal_ops = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1101};
        bad_ops   = '{4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};

        rst = 1'b1; req_valid = 1'b0; req_op = 4'b0; req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset rsp_result", {16'b0, rsp_result}, 32'h0);
        check("reset hi/lo", {hi, lo}, 32'h0);
        check("reset alu drive", {12'b0, alu_op, alu_lvalue | alu_rvalue}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, res, err, lat, aok, hok, pok);
            check($sformatf("vec%0d result", i), {16'b0, res}, {16'b0, vecs[i].res});
            check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d hi/lo", i), {hi, lo}, {vecs[i].ehi, vecs[i].elo});
            check($sformatf("vec%0d alu drive", i), {31'b0, aok}, 32'd1);
            check($sformatf("vec%0d held response", i), {31'b0, hok}, 32'd1);
            check($sformatf("vec%0d after handshake", i), {31'b0, pok}, 32'd1);
        end
        m_hi = 16'h0001;
        m_lo = 16'h0000;

        // Back-to-back with req_valid held: PASS then AND, one bubble between.
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'b0011; req_a = 16'h0000; req_b = 16'h00AB;
        @(posedge clk);
        @(negedge clk);
        req_op = 4'b0101; req_a = 16'hF0F0; req_b = 16'h0FF0;
        check("b2b exec req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b first rsp", {15'b0, rsp_valid, rsp_result}, {15'b0, 1'b1, 16'h00AB});
        check("b2b handshake req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b bubble", {30'b0, rsp_valid, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b second rsp", {15'b0, rsp_valid, rsp_result}, {15'b0, 1'b1, 16'h00F0});
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("b2b hi/lo kept", {hi, lo}, {m_hi, m_lo});
        check("b2b idle", {30'b0, rsp_valid, req_ready}, 32'd1);

        // Randomized ops against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [15:0] a, b, eres;
            logic [31:0] prod;
            logic        eerr;
            int          elat;
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 4) == 0) op = bad_ops[$urandom_range(0, 8)];
            else                           op = legal_ops[$urandom_range(0, 6)];
            if (op == 4'b0110 && $urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            eerr = 1'b0;
            elat = 2;
            case (op)
                4'b0000: eres = a + b;
                4'b0010: eres = a - b;
                4'b0011: eres = b;
                4'b0101: eres = a & b;
                4'b0110: eres = (b >= 16) ? 16'h0 : 16'(a * (32'd1 << b));
                4'b1101: eres = (a < b) ? 16'd1 : 16'd0;
                4'b0100: begin
                    prod = 32'(a) * 32'(b);
                    eres = prod[15:0];
                    m_hi = prod[31:16];
                    m_lo = prod[15:0];
                    elat = 17;
                end
                default: begin eres = 16'h0; eerr = 1'b1; elat = 1; end
            endcase
            do_op(op, a, b, $urandom_range(0, 2), res, err, lat, aok, hok, pok);
            check($sformatf("rand%0d op%0h result", n, op), {16'b0, res}, {16'b0, eres});
            check($sformatf("rand%0d err", n), {31'b0, err}, {31'b0, eerr});
            check($sformatf("rand%0d latency", n), lat, elat);
            check($sformatf("rand%0d hi/lo", n), {hi, lo}, {m_hi, m_lo});
            check($sformatf("rand%0d protocol", n), {29'b0, aok, hok, pok}, 32'd7);
        end

        // Reset five edges into a MUL: op discarded, hi/lo cleared, no response.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0100; req_a = 16'h0007; req_b = 16'h0009;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midmul reset hi/lo", {hi, lo}, 32'h0);
        check("midmul reset busy", {30'b0, busy, rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("midmul no response", {31'b0, seen}, 32'd0);
        check("midmul req_ready", {31'b0, req_ready}, 32'd1);
        check("midmul hi/lo stay 0", {hi, lo}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
